// File: rtl/tx_pulse_scheduler.sv
// Transmit pulse scheduler: gates the code generator once per PRI, with
// configuration shadowed at burst start and a guaranteed low gap between pulses.
module tx_pulse_scheduler #(
    parameter int CNT_W   = 16,
    parameter int MAX_DIG = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      cfg_num_dig,
    input  logic [31:0]      cfg_codigo,
    input  logic [31:0]      cfg_tiempo_b,
    input  logic [31:0]      cfg_periodo,
    input  logic [CNT_W-1:0] cfg_n_pulsos,
    output logic [31:0]      num_dig,
    output logic [31:0]      codigo,
    output logic [31:0]      tiempo_b,
    output logic             sinc,
    output logic             pulse_strobe,
    output logic [CNT_W-1:0] pulse_idx,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             trunc
);

    typedef enum logic [1:0] {IDLE, TX, WAIT, DONE} state_t;

    localparam logic [31:0] MAX_DIG_W = 32'(MAX_DIG);

    state_t           state;
    logic [31:0]      periodo_q;
    logic [CNT_W-1:0] n_pulsos_q;
    logic [31:0]      pc;
    logic [31:0]      wc;
    logic [5:0]       bc;

    logic cfg_ok;
    logic bit_last;
    logic code_end;
    logic pri_cut;
    logic pri_end;
    logic last_pulse;

    assign cfg_ok = (cfg_periodo >= 32'd2) && (cfg_num_dig != 32'd0) &&
                    (cfg_num_dig <= MAX_DIG_W) && (cfg_tiempo_b != 32'd0);

    // Bit counting mirrors the generator so the window length never needs a multiply.
    assign bit_last   = (wc == tiempo_b - 32'd1);
    assign code_end   = bit_last && ({26'd0, bc} == num_dig - 32'd1);
    assign pri_cut    = (pc == periodo_q - 32'd2);
    assign pri_end    = (pc == periodo_q - 32'd1);
    assign last_pulse = (n_pulsos_q != '0) && (pulse_idx == n_pulsos_q - CNT_W'(1));

    // NOTE: every register here is assigned with <= so all state updates see
    // the pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            num_dig      <= '0;
            codigo       <= '0;
            tiempo_b     <= '0;
            periodo_q    <= '0;
            n_pulsos_q   <= '0;
            pc           <= '0;
            wc           <= '0;
            bc           <= '0;
            sinc         <= 1'b0;
            pulse_strobe <= 1'b0;
            pulse_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_err      <= 1'b0;
            trunc        <= 1'b0;
        end else begin
            pulse_strobe <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (!cfg_ok) begin
                            cfg_err <= 1'b1;
                        end else begin
                            num_dig      <= cfg_num_dig;
                            codigo       <= cfg_codigo;
                            tiempo_b     <= cfg_tiempo_b;
                            periodo_q    <= cfg_periodo;
                            n_pulsos_q   <= cfg_n_pulsos;
                            cfg_err      <= 1'b0;
                            trunc        <= 1'b0;
                            pulse_idx    <= '0;
                            pc           <= '0;
                            wc           <= '0;
                            bc           <= '0;
                            sinc         <= 1'b1;
                            pulse_strobe <= 1'b1;
                            busy         <= 1'b1;
                            state        <= TX;
                        end
                    end
                end
                TX: begin
                    if (stop) begin
                        sinc  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        pc <= pc + 32'd1;
                        if (bit_last) begin
                            wc <= '0;
                            bc <= bc + 6'd1;
                        end else begin
                            wc <= wc + 32'd1;
                        end
                        // The PRI cut leaves one low cycle so the generator re-arms.
                        if (code_end || pri_cut) begin
                            sinc  <= 1'b0;
                            state <= WAIT;
                        end
                        if (pri_cut && !code_end) trunc <= 1'b1;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (pri_end) begin
                        if (last_pulse) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pulse_idx    <= pulse_idx + CNT_W'(1);
                            pc           <= '0;
                            wc           <= '0;
                            bc           <= '0;
                            sinc         <= 1'b1;
                            pulse_strobe <= 1'b1;
                            state        <= TX;
                        end
                    end else begin
                        pc <= pc + 32'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_pulse_scheduler.md
Name: tx_pulse_scheduler

Overview:
- Sequences the transmit code generator. Produces its `sinc` gate window once per pulse repetition period (PRI), for a programmed number of pulses or continuously.
- Shadow-latches the code configuration (`num_dig`, `codigo`, `tiempo_b`) at burst start, so the generator never sees a mid-burst change.
- Guarantees `sinc` is low for at least one cycle between pulses, so the generator clears its counters on every pulse.
- Sits between the AXI register bank (`cfg_*`) and the code generator inside the TX top.

Parameters:
- CNT_W, 16, width of `cfg_n_pulsos` and `pulse_idx`.
- MAX_DIG, 32, maximum legal `cfg_num_dig` (width of `codigo`).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle burst start request
- stop  in  1  one-cycle abort request
- cfg_num_dig  in  32  code length in bits
- cfg_codigo  in  32  code word, bit 0 transmitted first
- cfg_tiempo_b  in  32  clocks per code bit
- cfg_periodo  in  32  PRI in clocks
- cfg_n_pulsos  in  CNT_W  pulses per burst; 0 = continuous
- num_dig  out  32  latched code length, to generator
- codigo  out  32  latched code word, to generator
- tiempo_b  out  32  latched bit width, to generator
- sinc  out  1  generator gate
- pulse_strobe  out  1  one-cycle strobe at each pulse start (RX sync)
- pulse_idx  out  CNT_W  index of current pulse, starting at 0
- busy  out  1  burst in progress
- done  out  1  one-cycle strobe on normal burst completion
- cfg_err  out  1  sticky, rejected start
- trunc  out  1  sticky, pulse truncated by the PRI

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge): state IDLE. All outputs are 0, including the shadow registers, `pulse_idx` and the sticky flags.
- States: IDLE, TX, WAIT, DONE.
- Internal counters:
  - `pc`: period counter, 32 bits.
  - `wc`: bit-width counter, 32 bits.
  - `bc`: bit counter, 6 bits.
- IDLE:
  - When start=1 and stop=0, validate the live config.
  - Config is valid when `cfg_periodo` >= 2, 1 <= `cfg_num_dig` <= MAX_DIG and `cfg_tiempo_b` >= 1.
  - Invalid config: set `cfg_err`=1 and remain in IDLE.
  - Valid config:
    - Latch the shadow registers.
    - Clear `cfg_err` and `trunc`.
    - Set `pulse_idx`=0 and `pc`=`wc`=`bc`=0.
    - Enter TX.
  - Latency: start accepted at edge T; `sinc`, `pulse_strobe` and `busy` are 1 after edge T+1 (visible in cycle T+1).
  - start and stop in the same cycle: stop wins and start is ignored.
- Pulse timing:
  - Pulse k starts at cycle S_k; S_(k+1) = S_k + latched periodo.
  - `sinc`=1 for cycles S_k .. S_k+L-1, where L = min(num_dig*tiempo_b, periodo-1).
  - The product is never computed: `wc`/`bc` count bits exactly as the generator does.
- TX:
  - `sinc`=1. `pc` increments every cycle.
  - `wc` wraps at tiempo_b-1, and `bc` increments on that wrap.
  - Leave for WAIT after the cycle in which `bc`=num_dig-1 and `wc`=tiempo_b-1.
  - If `pc` reaches periodo-2 first, leave for WAIT after that cycle and set `trunc`=1.
- WAIT:
  - `sinc`=0. `pc` keeps incrementing.
  - At `pc`=periodo-1, if `cfg_n_pulsos` latched != 0 and `pulse_idx`=n_pulsos-1, go to DONE.
  - Otherwise: `pulse_idx`+1, `pc`=`wc`=`bc`=0, go to TX and assert `pulse_strobe`.
- `pulse_idx` wraps modulo 2^CNT_W in continuous mode.
- DONE: one cycle with `done`=1 and `busy`=0, then IDLE. `pulse_idx` holds its last value.
- `busy`=1 exactly in TX and WAIT.
- stop in TX or WAIT takes effect at the next edge:
  - State goes to IDLE; `sinc`, `busy` and `pulse_strobe` go to 0.
  - `done` is not asserted.
  - The shadow registers and `pulse_idx` hold.
- start while busy is ignored, with no error.
- Live `cfg_*` changes while busy have no effect; the shadow registers are updated only on an accepted start.
- `cfg_periodo`=2: L=1, so `sinc` alternates 1,0 per pulse.

Test Plan:
- Normal burst:
  - Stimulus: periodo=10, num_dig=3, tiempo_b=2, n_pulsos=2, start in cycle 0.
  - Response: `sinc`=1 in cycles 1–6 and 11–16; `pulse_strobe` in cycles 1 and 11; `pulse_idx`=1 from cycle 11; `busy` in cycles 1–20; `done` in cycle 21; `trunc`=0.
- Truncation:
  - Stimulus: periodo=5, num_dig=4, tiempo_b=2, n_pulsos=3.
  - Response: `sinc` high 4 cycles then low 1 cycle, repeating at period 5; `trunc`=1; `done` 15 cycles after the first pulse_strobe.
- Config error:
  - Stimulus: start with num_dig=0, then with num_dig=33, then with periodo=1.
  - Response: no `sinc`, `busy`=0, `cfg_err`=1 each time.
  - Follow-up: a valid start clears `cfg_err` in the cycle after acceptance.
- Abort:
  - Stimulus: n_pulsos=0 (continuous), periodo=20; stop in the 3rd cycle of pulse index 1.
  - Response: `sinc`/`busy` are 0 next cycle; `done` stays 0; `pulse_idx`=1.
  - Follow-up: start+stop in the same cycle in IDLE leaves `busy` at 0.
- Shadowing:
  - Stimulus: change `cfg_codigo` 0xA5→0x3C and `cfg_periodo` mid-burst.
  - Response: `codigo` output stays 0xA5 and the PRI is unchanged until the next accepted start.
- Reset mid-operation:
  - Stimulus: rst=0 for 1 cycle during TX.
  - Response: all outputs are 0 next cycle.
  - Follow-up: a following valid start produces a correct pulse train from `pulse_idx`=0.
